// File: rtl/jtframe_sim_inputs_pkg.sv
// Shared types for the scripted player-input generator: script entry layout,
// default script table and FSM state encoding.
package jtframe_sim_inputs_pkg;

    localparam int MAX_ENTRIES = 16;
    localparam int START_W     = 16;
    localparam int PAT_W       = 9;

    // Active-high pattern bits {coin, start, joy[6:0]}
    localparam logic [PAT_W-1:0] PAT_COIN  = 9'h100;
    localparam logic [PAT_W-1:0] PAT_START = 9'h080;
    localparam logic [PAT_W-1:0] PAT_B1    = 9'h010;
    localparam logic [PAT_W-1:0] PAT_RIGHT = 9'h001;
    localparam logic [PAT_W-1:0] PAT_REL   = 9'h1FF;

    typedef struct packed {
        logic [START_W-1:0] start;
        logic [7:0]         dur;
        logic [PAT_W-1:0]   pat;
    } entry_t;

    typedef entry_t [0:MAX_ENTRIES-1] script_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Unused slots carry dur=0 so they are skipped if NENTRIES reaches them
    localparam script_t SCRIPT = '{
        0:       '{16'd60,  8'd4,  PAT_COIN},
        1:       '{16'd120, 8'd4,  PAT_START},
        2:       '{16'd200, 8'd30, PAT_RIGHT},
        3:       '{16'd240, 8'd10, PAT_B1},
        default: '0
    };

endpackage

// File: rtl/jtframe_sim_inputs.sv
// Scripted player-input generator: counts frames (falling LVBL edges) and plays
// a table of coin/start/joystick events on registered active-low outputs.
module jtframe_sim_inputs
    import jtframe_sim_inputs_pkg::*;
#(
    parameter int      NENTRIES = 4,
    parameter int      FRAMEW   = 16,     // 1..START_W
    parameter bit      LOOP     = 1'b0,
    parameter script_t TABLE    = SCRIPT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_rst,
    input  logic       LVBL,
    output logic [6:0] game_joystick1,
    output logic       button_1p,
    output logic       coin_left
);

    logic              lvbl_l_q;
    logic [FRAMEW-1:0] frame_cnt_q;
    logic [FRAMEW-1:0] frame_cnt_d;
    logic [3:0]        idx_q;
    logic [7:0]        hold_q;
    state_t            state_q;
    logic [PAT_W-1:0]  out_q;

    logic              tick_s;
    logic              hit_s;
    logic              last_s;
    entry_t            cur_s;

    assign tick_s = lvbl_l_q & ~LVBL;
    assign cur_s  = TABLE[idx_q];
    // Compare against the counter value this edge will store, so an entry fires on its tick
    assign hit_s  = (START_W'(frame_cnt_d) >= cur_s.start);
    assign last_s = ({1'b0, idx_q} == 5'(NENTRIES - 1));

    // Saturating frame counter next-state
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (tick_s && (frame_cnt_q != {FRAMEW{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Edge detector, frame counter, script FSM and output register
    always_ff @(posedge clk) begin
        if (!rst_n || loop_rst) begin
            lvbl_l_q    <= 1'b1;
            frame_cnt_q <= '0;
            idx_q       <= 4'd0;
            hold_q      <= 8'd0;
            state_q     <= S_IDLE;
            out_q       <= PAT_REL;
        end else begin
            lvbl_l_q    <= LVBL;
            frame_cnt_q <= frame_cnt_d;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cur_s.dur == 8'd0) begin
                        // Zero-length entry: skip it through NEXT so end-of-table is handled once
                        state_q <= S_NEXT;
                    end else if (hit_s) begin
                        state_q <= S_HOLD;
                        hold_q  <= cur_s.dur;
                        out_q   <= ~cur_s.pat;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (tick_s) begin
                        hold_q <= hold_q - 8'd1;
                        if (hold_q == 8'd1) begin
                            out_q   <= PAT_REL;
                            state_q <= S_NEXT;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_NEXT: begin
                    if (last_s) begin
                        if (LOOP) begin
                            frame_cnt_q <= '0;
                            idx_q       <= 4'd0;
                            state_q     <= S_WAIT;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= PAT_REL;
                end
            endcase
        end
    end

    assign game_joystick1 = out_q[6:0];
    assign button_1p      = out_q[7];
    assign coin_left      = out_q[8];

endmodule

// File: tb/tb_jtframe_sim_inputs.sv
// Scoreboard bench: four generator instances share one LVBL stream; every output
// change is popped against an expected (tick, value) pushed by the stimulus side.
module tb_jtframe_sim_inputs;
    import jtframe_sim_inputs_pkg::*;

    typedef struct packed {
        logic [31:0] tick;
        logic [8:0]  val;
    } exp_t;

    localparam script_t T_OVL = '{
        0:       '{16'd10, 8'd20, 9'h100},
        1:       '{16'd15, 8'd2,  9'h080},
        2:       '{16'd40, 8'd0,  9'h004},
        3:       '{16'd50, 8'd3,  9'h002},
        default: '0
    };
    localparam script_t T_SAT  = '{0: '{16'd15, 8'd2, 9'h080}, default: '0};
    localparam script_t T_SATL = '{0: '{16'd15, 8'd2, 9'h100}, default: '0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loop_rst0 = 1'b0;
    logic       lvbl = 1'b1;
    logic [6:0] joy_s  [4];
    logic       btn_s  [4];
    logic       coin_s [4];

    int   checks = 0;
    int   failures = 0;
    int   ticks = 0;
    int   base = 0;
    logic mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    jtframe_sim_inputs u0 (
        .clk(clk), .rst_n(rst_n), .loop_rst(loop_rst0), .LVBL(lvbl),
        .game_joystick1(joy_s[0]), .button_1p(btn_s[0]), .coin_left(coin_s[0]));

    jtframe_sim_inputs #(.NENTRIES(4), .FRAMEW(16), .LOOP(1'b0), .TABLE(T_OVL)) u1 (
        .clk(clk), .rst_n(rst_n), .loop_rst(1'b0), .LVBL(lvbl),
        .game_joystick1(joy_s[1]), .button_1p(btn_s[1]), .coin_left(coin_s[1]));

    jtframe_sim_inputs #(.NENTRIES(1), .FRAMEW(4), .LOOP(1'b0), .TABLE(T_SAT)) u2 (
        .clk(clk), .rst_n(rst_n), .loop_rst(1'b0), .LVBL(lvbl),
        .game_joystick1(joy_s[2]), .button_1p(btn_s[2]), .coin_left(coin_s[2]));

    jtframe_sim_inputs #(.NENTRIES(1), .FRAMEW(4), .LOOP(1'b1), .TABLE(T_SATL)) u3 (
        .clk(clk), .rst_n(rst_n), .loop_rst(1'b0), .LVBL(lvbl),
        .game_joystick1(joy_s[3]), .button_1p(btn_s[3]), .coin_left(coin_s[3]));

    function automatic logic [8:0] obs(input int i);
        return {coin_s[i], btn_s[i], joy_s[i]};
    endfunction

    task automatic sb_push(input int id, input int t, input logic [8:0] v);
        exp_t e;
        e.tick = t;
        e.val  = v;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic sb_pop(input int id, output exp_t e);
        case (id)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (tick %0d)", name, act, req, ticks);
        end
    endtask

    // Counts a falling LVBL edge; the looping instance's expectations follow a 17-tick period
    task automatic tick_edge();
        @(posedge clk);
        ticks++;
        if (ticks >= 15 && ((ticks - 15) % 17) == 0) sb_push(3, ticks, 9'h0FF);
        if (ticks >= 17 && ((ticks - 17) % 17) == 0) sb_push(3, ticks, 9'h1FF);
    endtask

    // One frame: 4 clocks, LVBL low for the first
    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            @(negedge clk) lvbl = 1'b0;
            tick_edge();
            @(negedge clk) lvbl = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    // Monitor: any change on a DUT's outputs must match the head of its queue
    initial begin
        logic [8:0] prev [4];
        logic [8:0] cur;
        exp_t       e;
        for (int i = 0; i < 4; i++) prev[i] = 9'h1FF;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                cur = obs(i);
                if (mon_en && (cur !== prev[i])) begin
                    if (sb_size(i) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_change dut%0d actual=%0h required=%0h (tick %0d)",
                                 i, cur, prev[i], ticks);
                    end else begin
                        sb_pop(i, e);
                        chk($sformatf("dut%0d_tick", i), ticks, e.tick);
                        chk($sformatf("dut%0d_val", i), {23'd0, cur}, {23'd0, e.val});
                    end
                end
                prev[i] = cur;
            end
        end
    end

    initial begin
        // Reset for three edges with LVBL toggling
        @(negedge clk) lvbl = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("reset_out%0d", i), {23'd0, obs(i)}, 32'h1FF);
        @(negedge clk) lvbl = 1'b1;
        @(negedge clk) lvbl = 1'b0;
        @(negedge clk) begin lvbl = 1'b1; rst_n = 1'b1; end

        sb_push(0,  60, 9'h0FF); sb_push(0,  64, 9'h1FF);
        sb_push(0, 120, 9'h17F); sb_push(0, 124, 9'h1FF);
        sb_push(0, 200, 9'h1FE); sb_push(0, 230, 9'h1FF);
        sb_push(0, 240, 9'h1EF); sb_push(0, 250, 9'h1FF);
        sb_push(1,  10, 9'h0FF); sb_push(1,  30, 9'h1FF);
        sb_push(1,  30, 9'h17F); sb_push(1,  32, 9'h1FF);
        sb_push(1,  50, 9'h1FD); sb_push(1,  53, 9'h1FF);
        sb_push(2,  15, 9'h17F); sb_push(2,  17, 9'h1FF);
        mon_en = 1'b1;

        // Full default script, then 100 idle frames in DONE
        frames(350);
        chk("done_hold", {23'd0, obs(0)}, 32'h1FF);

        // Restart from DONE via loop_rst, then interrupt e2 mid-HOLD
        @(negedge clk) loop_rst0 = 1'b1;
        @(negedge clk) loop_rst0 = 1'b0;
        base = ticks;
        sb_push(0, base + 60,  9'h0FF); sb_push(0, base + 64,  9'h1FF);
        sb_push(0, base + 120, 9'h17F); sb_push(0, base + 124, 9'h1FF);
        sb_push(0, base + 200, 9'h1FE);
        frames(210);
        sb_push(0, ticks, 9'h1FF);
        loop_rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("loop_rst_joy", {25'd0, joy_s[0]}, 32'h7F);

        // Tick coincident with loop_rst must not be counted
        @(negedge clk) lvbl = 1'b0;
        tick_edge();
        #1;
        chk("coincide_out", {23'd0, obs(0)}, 32'h1FF);
        @(negedge clk) begin lvbl = 1'b1; loop_rst0 = 1'b0; end
        base = ticks;
        sb_push(0, base + 60, 9'h0FF); sb_push(0, base + 64, 9'h1FF);
        repeat (2) @(negedge clk);
        frames(70);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) chk($sformatf("sb_drain%0d", i), sb_size(i), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
